// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter in front of a 4x16 RAM.
// Each transaction runs IDLE -> SETUP -> ACCESS -> DONE. Every output is
// driven straight from a flop.
`timescale 1ns/1ps

module ram_arbiter (
    input  logic        clk,
    input  logic        clear,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_rw,
    input  logic        b_rw,
    input  logic [1:0]  a_addr,
    input  logic [1:0]  b_addr,
    input  logic [15:0] a_wdata,
    input  logic [15:0] b_wdata,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_done,
    output logic        b_done,
    output logic [15:0] a_rdata,
    output logic [15:0] b_rdata,
    output logic [1:0]  ram_addr,
    output logic        ram_r_w,
    output logic [15:0] ram_in,
    input  logic [15:0] ram_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // FSM state and transaction context
    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;   // 1: requester B was served last
    logic        win_b_q, win_b_d;     // 1: current transaction belongs to B
    logic        rw_q, rw_d;           // latched read/write of the winner

    // Registered outputs; ram_addr_q/ram_in_q double as the latched
    // address and write data of the winner
    logic [1:0]  ram_addr_q, ram_addr_d;
    logic [15:0] ram_in_q, ram_in_d;
    logic        ram_r_w_q, ram_r_w_d;
    logic        a_gnt_q, a_gnt_d;
    logic        b_gnt_q, b_gnt_d;
    logic        a_done_q, a_done_d;
    logic        b_done_q, b_done_d;
    logic [15:0] a_rdata_q, a_rdata_d;
    logic [15:0] b_rdata_q, b_rdata_d;
    logic        busy_q, busy_d;

    // Round-robin choice: B wins if it is alone, or if both request and
    // A was served last.
    logic        pick_b;
    assign pick_b = b_req & (~a_req | ~last_b_q);

    // Next-state and next-output logic for the whole arbiter
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        last_b_d   = last_b_q;
        win_b_d    = win_b_q;
        rw_d       = rw_q;
        ram_addr_d = ram_addr_q;
        ram_in_d   = ram_in_q;
        ram_r_w_d  = 1'b0;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_done_d   = 1'b0;
        b_done_d   = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    win_b_d    = pick_b;
                    rw_d       = pick_b ? b_rw    : a_rw;
                    ram_addr_d = pick_b ? b_addr  : a_addr;
                    ram_in_d   = pick_b ? b_wdata : a_wdata;
                    a_gnt_d    = ~pick_b;
                    b_gnt_d    = pick_b;
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                // Address and data have settled for a cycle; strobe now.
                ram_r_w_d = rw_q;
                state_d   = ACCESS;
            end

            ACCESS: begin
                // The edge leaving ACCESS samples the RAM read data.
                if (!rw_q) begin
                    if (win_b_q) b_rdata_d = ram_out;
                    else         a_rdata_d = ram_out;
                end
                a_done_d = ~win_b_q;
                b_done_d = win_b_q;
                last_b_d = win_b_q;
                state_d  = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous clear
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // flops update together from values sampled before the edge.
        if (clear) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            win_b_q    <= 1'b0;
            rw_q       <= 1'b0;
            ram_addr_q <= 2'd0;
            ram_in_q   <= 16'd0;
            ram_r_w_q  <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            a_rdata_q  <= 16'd0;
            b_rdata_q  <= 16'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            win_b_q    <= win_b_d;
            rw_q       <= rw_d;
            ram_addr_q <= ram_addr_d;
            ram_in_q   <= ram_in_d;
            ram_r_w_q  <= ram_r_w_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign a_done   = a_done_q;
    assign b_done   = b_done_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_r_w  = ram_r_w_q;
    assign ram_in   = ram_in_q;
    assign busy     = busy_q;

endmodule
